// File: rtl/axi_r_line_pkg.sv
// axi_r_line_pkg: shared state/response types for the R-channel line collector.
// Widths come from salyut1_soc_config.svh when it is part of the build; fallbacks below.
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

package axi_r_line_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } r_line_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int LINE_BEATS_DEFAULT = 4;
    localparam int AXI_DW_DEFAULT     = `AXI_DATA_WIDTH;
    localparam int AXI_IDW_DEFAULT    = `AXI_ID_WIDTH;

endpackage

// File: rtl/sys_axi_r.sv
// sys_axi_r: AXI read-data channel bundle.
// master drives rid/rdata/rresp/rlast/rvalid; slave drives rready.
interface sys_axi_r #(
    parameter int DW  = axi_r_line_pkg::AXI_DW_DEFAULT,
    parameter int IDW = axi_r_line_pkg::AXI_IDW_DEFAULT
);
    logic [IDW-1:0] rid;
    logic [DW-1:0]  rdata;
    logic [1:0]     rresp;
    logic           rlast;
    logic           rvalid;
    logic           rready;

    modport master (
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport slave (
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_r_line_collect.sv
// axi_r_line_collect: assembles one AXI R burst into a cache line and offers it
// downstream through a valid/ready handshake.
// Ports: clk_i, arst_n (async, active-low); axi_r (sys_axi_r.slave);
//   line_valid_o/line_ready_i handshake; line_data_o (beat k at [k*DW +: DW]),
//   line_id_o, line_resp_o (first non-OKAY resp), line_err_o.
// Option: define AXI_R_LINE_ID_CHECK_EN to flag rid changes within a burst.
module axi_r_line_collect
    import axi_r_line_pkg::*;
#(
    parameter int LINE_BEATS = LINE_BEATS_DEFAULT,
    parameter int DW         = AXI_DW_DEFAULT,
    parameter int IDW        = AXI_IDW_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     arst_n,
    sys_axi_r.slave                  axi_r,
    output logic                     line_valid_o,
    input  logic                     line_ready_i,
    output logic [LINE_BEATS*DW-1:0] line_data_o,
    output logic [IDW-1:0]           line_id_o,
    output logic [1:0]               line_resp_o,
    output logic                     line_err_o
);

    localparam int CW = $clog2(LINE_BEATS) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(LINE_BEATS);
    localparam logic [CW-1:0] CNT_LAST = CW'(LINE_BEATS - 1);

    r_line_state_e           state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [LINE_BEATS*DW-1:0] data_q, data_d;
    logic [IDW-1:0]          id_q, id_d;
    logic [1:0]              resp_q, resp_d;
    logic                    err_q, err_d;
    logic                    rready_q, rready_d;
    logic                    valid_q, valid_d;
    logic                    beat_acc;

    assign beat_acc = axi_r.rvalid && rready_q;

    always_ff @(posedge clk_i or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            id_q     <= '0;
            resp_q   <= RESP_OKAY;
            err_q    <= 1'b0;
            rready_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            id_q     <= id_d;
            resp_q   <= resp_d;
            err_q    <= err_d;
            rready_q <= rready_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        id_d    = id_q;
        resp_d  = resp_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (beat_acc) begin
                    id_d              = axi_r.rid;
                    cnt_d             = CW'(1);
                    data_d            = '0;
                    data_d[DW-1:0]    = axi_r.rdata;
                    resp_d            = axi_r.rresp;
                    err_d             = axi_r.rresp[1];
                    if (axi_r.rlast) begin
                        // One-beat burst is always short (LINE_BEATS >= 2).
                        state_d = HOLD;
                        err_d   = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end
            end

            FILL: begin
                if (beat_acc) begin
                    if (cnt_q == CNT_FULL) begin
                        // Overrun: drop data, keep consuming until rlast.
                        err_d = 1'b1;
                    end else begin
                        for (int k = 0; k < LINE_BEATS; k++) begin
                            if (CW'(k) == cnt_q) begin
                                data_d[k*DW +: DW] = axi_r.rdata;
                            end
                        end
                        cnt_d = cnt_q + CW'(1);
                    end

                    if (resp_q == RESP_OKAY) begin
                        resp_d = axi_r.rresp;
                    end
                    if (axi_r.rresp[1]) begin
                        err_d = 1'b1;
                    end
`ifdef AXI_R_LINE_ID_CHECK_EN
                    if (axi_r.rid != id_q) begin
                        err_d = 1'b1;
                    end
`endif
                    if (axi_r.rlast) begin
                        state_d = HOLD;
                        // cnt_q beats stored before this one.
                        if (cnt_q < CNT_LAST) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end

            HOLD: begin
                if (line_ready_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rready_d = (state_d != HOLD);
    assign valid_d  = (state_d == HOLD);

    assign axi_r.rready = rready_q;
    assign line_valid_o = valid_q;
    assign line_data_o  = data_q;
    assign line_id_o    = id_q;
    assign line_resp_o  = resp_q;
    assign line_err_o   = err_q;

endmodule
